av_cart_loader: RTL and testbench
=================================

Name: av_cart_loader

Overview:
- Sequences HPS ioctl downloads into the 4 KB cartridge dual-port RAM and owns that RAM's write port during loading and padding.
- Tracks the loaded image size and pads the rest of the next power-of-two window with a fill byte.
- Holds the console in reset until a valid image is present.
- Produces the address mask used to mirror undersized images into the CPU cartridge address space.

Parameters:
- ADDR_W, 12, cart RAM address width (depth 2^ADDR_W bytes)
- MIN_W, 8, log2 of the minimum mirror window (256 bytes)
- FILL_BYTE, 8'hFF, byte written into padding locations
- CART_INDEX, 8'd1, ioctl_index value accepted as a cartridge image

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high; driven from user/OSD reset only, never from ioctl_download
- ioctl_download  in  1  HPS download active
- ioctl_index  in  8  download target index
- ioctl_wr  in  1  one-cycle byte strobe
- ioctl_addr  in  25  byte address of ioctl_dout
- ioctl_dout  in  8  download byte
- ioctl_wait  out  1  stall request to HPS
- ram_we  out  1  cart RAM write enable, port A
- ram_addr  out  ADDR_W  cart RAM write address
- ram_din  out  8  cart RAM write data
- cpu_addr_i  in  ADDR_W  console cartridge address
- cpu_addr_o  out  ADDR_W  cpu_addr_i AND cart_mask (combinational from registered mask)
- cart_mask  out  ADDR_W  mirror mask
- cart_size  out  ADDR_W+1  bytes loaded, saturating at 2^ADDR_W
- loaded  out  1  valid image present
- overflow  out  1  last image exceeded RAM depth
- core_reset  out  1  hold console in reset

Behaviour:
- Reset values: state IDLE; ioctl_wait=0; ram_we=0; ram_addr=0; ram_din=0; cart_mask all ones; cart_size=0; loaded=0; overflow=0; core_reset=1. RAM contents are not cleared.
- Start detection: registered rising edge of (ioctl_download && ioctl_index==CART_INDEX). Downloads with another index cause no writes and no state change.
- IDLE / DONE:
  - On start: enter LOAD; clear cart_size and overflow; loaded=0; core_reset=1.
- LOAD:
  - ioctl_wait=0.
  - ioctl_wr with ioctl_addr < 2^ADDR_W: next cycle ram_we=1, ram_addr=ioctl_addr[ADDR_W-1:0], ram_din=ioctl_dout. Latency is exactly 1 cycle.
  - cart_size <= max(cart_size, ioctl_addr+1).
  - ioctl_wr with ioctl_addr >= 2^ADDR_W: no write; overflow=1; cart_size=2^ADDR_W.
  - On ioctl_download falling:
    - cart_size==0: back to IDLE with loaded=0 and core_reset=1.
    - Otherwise compute win = max(2^MIN_W, smallest power of two >= cart_size); cart_mask = win-1.
    - cart_size < win: go to FILL with fill pointer = cart_size.
    - Else go to DONE.
- FILL:
  - ioctl_wait=1.
  - One write per cycle: ram_we=1, ram_addr=pointer, ram_din=FILL_BYTE. Pointer increments until win-1 is written, then DONE.
  - A qualifying start during FILL is latched as pending. When the fill completes, it enters LOAD instead of DONE. The HPS is stalled by ioctl_wait, so no bytes are lost.
- DONE: ioctl_wait=0; loaded=1; core_reset=0 from the first DONE cycle onward.
- Port A is written only by this block. ram_we is never asserted in IDLE or DONE.
- Reset mid-LOAD or mid-FILL: return to reset values immediately. A download still active after reset is ignored until its next rising edge.
- All size arithmetic uses ADDR_W+1 bits. No wrap-around of cart_size.

Test Plan:
- 4096-byte CART_INDEX download, bytes = addr[7:0] -> 4096 ram_we pulses each 1 cycle after ioctl_wr; no FILL; cart_size=4096, cart_mask=12'hFFF, loaded=1, core_reset=0.
- 1000-byte download -> FILL writes 8'hFF to addresses 1000..1023 (24 cycles, ioctl_wait high throughout); cart_mask=12'h3FF; cpu_addr_i=12'h7E8 gives cpu_addr_o=12'h3E8.
- 100-byte download -> window clamps to 256; fill 100..255; cart_mask=12'h0FF.
- 5000-byte download -> addresses 4096..4999 produce no ram_we; overflow=1, cart_size=4096, no FILL, loaded=1.
- ioctl_index=8'd2 download -> no ram_we; loaded/core_reset unchanged.
- Reset asserted after 500 bytes of a load -> next cycle ram_we=0, loaded=0, core_reset=1; remaining ioctl_wr produce no writes. A new download then loads normally.

Source files
------------

// File: rtl/av_cart_loader.sv
// ---------------------------------------------------------------------------
// av_cart_loader
//
// Purpose:
//   Moves HPS ioctl cartridge downloads into the cartridge dual-port RAM
//   through port A. It records how many bytes were loaded and pads the rest
//   of the next power-of-two window with FILL_BYTE. The console is held in
//   reset until a valid image is present. The block also produces the
//   address mask that mirrors undersized images across the CPU cartridge
//   space.
//
// Ports:
//   clk_sys         system clock
//   reset           synchronous, active-high (user/OSD reset only)
//   ioctl_download  HPS download active
//   ioctl_index     download target index; only CART_INDEX is accepted
//   ioctl_wr        one-cycle byte strobe
//   ioctl_addr      byte address of ioctl_dout
//   ioctl_dout      download byte
//   ioctl_wait      stall request to the HPS (high while padding)
//   ram_we          cart RAM port A write enable
//   ram_addr        cart RAM port A write address
//   ram_din         cart RAM port A write data
//   cpu_addr_i      console cartridge address
//   cpu_addr_o      cpu_addr_i masked by cart_mask
//   cart_mask       mirror mask (window size - 1)
//   cart_size       bytes loaded, saturating at 2^ADDR_W
//   loaded          a valid image is present
//   overflow        the last image was larger than the RAM
//   core_reset      holds the console in reset
//   dbg_state       current FSM state, for observation only
//
// HPS handshake:
//   The HPS presents a byte by pulsing ioctl_wr for one cycle. It must not
//   pulse ioctl_wr while ioctl_wait is high. This block accepts every strobe
//   that arrives while ioctl_wait is low, and a strobe in LOAD reaches the
//   RAM port exactly one cycle later.
// ---------------------------------------------------------------------------
module av_cart_loader #(
    parameter int         ADDR_W     = 12,
    parameter int         MIN_W      = 8,
    parameter logic [7:0] FILL_BYTE  = 8'hFF,
    parameter logic [7:0] CART_INDEX = 8'd1
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              ioctl_wait,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_din,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    output logic [ADDR_W-1:0] cpu_addr_o,
    output logic [ADDR_W-1:0] cart_mask,
    output logic [ADDR_W:0]   cart_size,
    output logic              loaded,
    output logic              overflow,
    output logic              core_reset,
    output logic [1:0]        dbg_state
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_FILL = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [ADDR_W:0] ONE      = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] DEPTH    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [24:0]     DEPTH_25 = 25'(DEPTH);

    // Smallest power of two >= size, never below 2^MIN_W. Scanning from the
    // largest window down leaves the smallest window that still fits.
    function automatic logic [ADDR_W:0] window_for(input logic [ADDR_W:0] size);
        logic [ADDR_W:0] w;
        w = DEPTH;
        for (int k = ADDR_W; k >= MIN_W; k--) begin
            if (size <= (ONE << k)) begin
                w = ONE << k;
            end
        end
        return w;
    endfunction

    logic [1:0]        state_q,    state_d;
    logic              qual_q;
    logic              pend_q,     pend_d;
    logic              ram_we_q,   ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]        ram_din_q,  ram_din_d;
    logic [ADDR_W-1:0] mask_q,     mask_d;
    logic [ADDR_W:0]   size_q,     size_d;
    logic              ovf_q,      ovf_d;
    logic [ADDR_W:0]   ptr_q,      ptr_d;
    logic [ADDR_W:0]   win_q,      win_d;

    logic            qual;
    logic            start;
    logic            in_range;
    logic [ADDR_W:0] addr_p1;
    logic [ADDR_W:0] win_new;
    logic [ADDR_W:0] win_m1;

    always_comb begin
        qual     = ioctl_download && (ioctl_index == CART_INDEX);
        start    = qual && !qual_q;
        in_range = (ioctl_addr < DEPTH_25);
        addr_p1  = {1'b0, ioctl_addr[ADDR_W-1:0]} + ONE;
        win_new  = window_for(size_q);
        win_m1   = win_new - ONE;

        state_d    = state_q;
        pend_d     = pend_q;
        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        mask_d     = mask_q;
        size_d     = size_q;
        ovf_d      = ovf_q;
        ptr_d      = ptr_q;
        win_d      = win_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    size_d  = '0;
                    ovf_d   = 1'b0;
                end
            end

            ST_LOAD: begin
                if (ioctl_wr) begin
                    if (in_range) begin
                        ram_we_d   = 1'b1;
                        ram_addr_d = ioctl_addr[ADDR_W-1:0];
                        ram_din_d  = ioctl_dout;
                        if (addr_p1 > size_q) begin
                            size_d = addr_p1;
                        end
                    end else begin
                        size_d = DEPTH;
                        ovf_d  = 1'b1;
                    end
                end else if (!ioctl_download) begin
                    // The end of the download is handled on the first idle
                    // cycle with download low. A strobe that arrives in that
                    // same cycle is stored first, and the image is finished
                    // one cycle later.
                    if (size_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        mask_d = win_m1[ADDR_W-1:0];
                        win_d  = win_new;
                        if (size_q < win_new) begin
                            // The first pad write leaves on the transition
                            // into FILL, so every FILL cycle carries a write.
                            state_d    = ST_FILL;
                            ram_we_d   = 1'b1;
                            ram_addr_d = size_q[ADDR_W-1:0];
                            ram_din_d  = FILL_BYTE;
                            ptr_d      = size_q + ONE;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end

            ST_FILL: begin
                if (start) begin
                    pend_d = 1'b1;
                end
                if (ptr_q == win_q) begin
                    if (pend_q || start) begin
                        state_d = ST_LOAD;
                        pend_d  = 1'b0;
                        size_d  = '0;
                        ovf_d   = 1'b0;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    ram_we_d   = 1'b1;
                    ram_addr_d = ptr_q[ADDR_W-1:0];
                    ram_din_d  = FILL_BYTE;
                    ptr_d      = ptr_q + ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        // The edge detector follows the live download level even in reset.
        // A download that is still active when reset is released then shows
        // no rising edge and is ignored.
        qual_q <= qual;
        if (reset) begin
            state_q    <= ST_IDLE;
            pend_q     <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            mask_q     <= '1;
            size_q     <= '0;
            ovf_q      <= 1'b0;
            ptr_q      <= '0;
            win_q      <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            mask_q     <= mask_d;
            size_q     <= size_d;
            ovf_q      <= ovf_d;
            ptr_q      <= ptr_d;
            win_q      <= win_d;
        end
    end

    assign ioctl_wait = (state_q == ST_FILL);
    assign ram_we     = ram_we_q;
    assign ram_addr   = ram_addr_q;
    assign ram_din    = ram_din_q;
    assign cart_mask  = mask_q;
    assign cpu_addr_o = cpu_addr_i & mask_q;
    assign cart_size  = size_q;
    assign overflow   = ovf_q;
    assign loaded     = (state_q == ST_DONE);
    assign core_reset = (state_q != ST_DONE);
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_av_cart_loader.sv
// Bench for av_cart_loader. The reference model works from image lengths and
// addresses with plain integer arithmetic. Every expected RAM write, whether
// a loaded byte or a pad byte, is queued in exp_q and matched against port A.
module tb_av_cart_loader;

  localparam logic [7:0] CART = 8'd1;
  localparam int EW = 53;  // {is_fill, expected cycle, addr[11:0], data[7:0]}

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        ioctl_wait;
  logic        ram_we;
  logic [11:0] ram_addr;
  logic [7:0]  ram_din;
  logic [11:0] cpu_addr_i = '0;
  logic [11:0] cpu_addr_o;
  logic [11:0] cart_mask;
  logic [12:0] cart_size;
  logic        loaded;
  logic        overflow;
  logic        core_reset;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [EW-1:0] exp_q[$];

  // model view of the current image
  int          e_size;
  logic [11:0] e_mask;
  logic        e_ovf;
  logic        e_loaded;

  av_cart_loader dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .ram_we         (ram_we),
    .ram_addr       (ram_addr),
    .ram_din        (ram_din),
    .cpu_addr_i     (cpu_addr_i),
    .cpu_addr_o     (cpu_addr_o),
    .cart_mask      (cart_mask),
    .cart_size      (cart_size),
    .loaded         (loaded),
    .overflow       (overflow),
    .core_reset     (core_reset),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard on RAM port A ----------------
  always @(negedge clk_sys) begin
    logic [EW-1:0] e;
    if (ram_we === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_write observed addr=%0h data=%0h expected no write", ram_addr, ram_din);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("write_addr", 32'(ram_addr), 32'(e[19:8]));
        check("write_data", 32'(ram_din), 32'(e[7:0]));
        if (e[52]) check("fill_wait", 32'(ioctl_wait), 32'd1);
        else       check("write_latency", 32'(cyc), e[51:20]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk_sys); #1;
  endtask

  // mode 1: byte = addr[7:0]; mode 0: random bytes
  task automatic do_download(input int nbytes, input int mode, input logic [7:0] idx,
                             input int max_gap);
    int m_max;
    logic m_ovf;
    logic [7:0] d;
    int win;
    int to;
    m_max = 0;
    m_ovf = 1'b0;
    ioctl_index = idx;
    ioctl_download = 1'b1;
    repeat (2) step();
    for (int a = 0; a < nbytes; a++) begin
      to = 0;
      while (ioctl_wait === 1'b1 && to < 5000) begin
        step();
        to++;
      end
      if (to != 0) check("wait_release", 32'(to < 5000), 32'd1);
      d = (mode == 1) ? a[7:0] : 8'($urandom);
      ioctl_wr = 1'b1;
      ioctl_addr = 25'(a);
      ioctl_dout = d;
      if (idx == CART) begin
        if (a < 4096) begin
          exp_q.push_back({1'b0, 32'(cyc + 1), 12'(a), d});
          if (a + 1 > m_max) m_max = a + 1;
        end else begin
          m_ovf = 1'b1;
        end
      end
      step();
      ioctl_wr = 1'b0;
      repeat ($urandom_range(0, max_gap)) step();
    end
    ioctl_download = 1'b0;
    if (idx == CART) begin
      e_size = m_ovf ? 4096 : m_max;
      e_ovf = m_ovf;
      if (e_size == 0) begin
        e_loaded = 1'b0;
      end else begin
        win = 256;
        while (win < e_size) win = win * 2;
        e_mask = 12'(win - 1);
        e_loaded = 1'b1;
        for (int f = e_size; f < win; f++) exp_q.push_back({1'b1, 32'd0, 12'(f), 8'hFF});
      end
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20000) begin
      @(negedge clk_sys);
      n++;
    end
    check("drain_timeout", 32'(n < 20000), 32'd1);
    repeat (3) @(negedge clk_sys);
  endtask

  task automatic check_result(input logic [11:0] cpu);
    step();
    cpu_addr_i = cpu;
    @(negedge clk_sys);
    check("cart_size", 32'(cart_size), 32'(e_size));
    check("cart_mask", 32'(cart_mask), 32'(e_mask));
    check("overflow", 32'(overflow), 32'(e_ovf));
    check("loaded", 32'(loaded), 32'(e_loaded));
    check("core_reset", 32'(core_reset), 32'(!e_loaded));
    check("ioctl_wait_idle", 32'(ioctl_wait), 32'd0);
    check("cpu_addr_o", 32'(cpu_addr_o), 32'(cpu & e_mask));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int len;
    e_size = 0;
    e_mask = 12'hFFF;
    e_ovf = 1'b0;
    e_loaded = 1'b0;

    repeat (3) step();
    reset = 1'b0;
    @(negedge clk_sys);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_din", 32'(ram_din), 32'd0);
    check("rst_mask", 32'(cart_mask), 32'hFFF);
    check("rst_size", 32'(cart_size), 32'd0);
    check("rst_loaded", 32'(loaded), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_core_reset", 32'(core_reset), 32'd1);
    check("rst_wait", 32'(ioctl_wait), 32'd0);

    // full 4 KB image, no padding
    do_download(4096, 1, CART, 1);
    wait_drain();
    check_result(12'($urandom));

    // 1000 bytes: pad 1000..1023, mirror at 1 KB
    do_download(1000, 0, CART, 1);
    wait_drain();
    check_result(12'h7E8);

    // 100 bytes: window clamps to 256
    do_download(100, 0, CART, 1);
    wait_drain();
    check_result(12'($urandom));

    // new download raised while padding is still running
    do_download(200, 0, CART, 1);
    repeat (3) step();
    do_download(700, 0, CART, 1);
    wait_drain();
    check_result(12'($urandom));

    // oversized image
    do_download(5000, 0, CART, 0);
    wait_drain();
    check_result(12'($urandom));

    // other index: no writes, nothing changes
    do_download(50, 0, 8'd2, 1);
    wait_drain();
    check_result(12'($urandom));

    // reset in the middle of a load
    ioctl_index = CART;
    ioctl_download = 1'b1;
    repeat (2) step();
    for (int a = 0; a < 500; a++) begin
      ioctl_wr = 1'b1;
      ioctl_addr = 25'(a);
      ioctl_dout = 8'($urandom);
      exp_q.push_back({1'b0, 32'(cyc + 1), 12'(a), ioctl_dout});
      step();
    end
    ioctl_wr = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk_sys);
    check("midrst_ram_we", 32'(ram_we), 32'd0);
    check("midrst_loaded", 32'(loaded), 32'd0);
    check("midrst_core_reset", 32'(core_reset), 32'd1);
    check("midrst_size", 32'(cart_size), 32'd0);
    step();
    for (int a = 500; a < 1000; a++) begin
      ioctl_wr = 1'b1;
      ioctl_addr = 25'(a);
      ioctl_dout = 8'($urandom);
      step();
    end
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    e_size = 0;
    e_mask = 12'hFFF;
    e_ovf = 1'b0;
    e_loaded = 1'b0;
    wait_drain();
    check_result(12'($urandom));

    // normal load after the reset
    do_download(300, 0, CART, 1);
    wait_drain();
    check_result(12'($urandom));

    // random lengths
    for (int i = 0; i < 3; i++) begin
      len = $urandom_range(1, 2500);
      do_download(len, 0, CART, 1);
      wait_drain();
      check_result(12'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
